// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response interface
// Master is the fetch stage; slave is the instruction memory.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with credit-limited requests and redirect flush
// In-flight PCs wait in a PC FIFO; returned words join their PC in the instruction FIFO.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic         fetch_valid,
  output logic [31:0]  fetch_inst,
  output logic [31:0]  fetch_pc
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pf_wr_q, pf_rd_q, if_wr_q, if_rd_q;
  logic [31:0]   pf_pc   [DEPTH];
  logic [31:0]   if_pc   [DEPTH];
  logic [31:0]   if_inst [DEPTH];
  logic          accept, rsp, rsp_keep, rsp_drop, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // out_q counts every in-flight request, including those already marked for dropping
  assign imem.imem_req_valid = (state_q != IDLE) &&
                               (({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C);
  assign imem.imem_req_addr  = req_pc_q;

  assign accept   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp      = imem.imem_rsp_valid && (out_q != '0);
  assign rsp_drop = rsp && (drop_q != '0);
  assign rsp_keep = rsp && (drop_q == '0);

  assign fetch_valid = (cnt_q != '0);
  assign pop         = fetch_valid && !stall && !redirect;
  assign fetch_inst  = fetch_valid ? if_inst[if_rd_q] : NOP;
  assign fetch_pc    = fetch_valid ? if_pc[if_rd_q] : req_pc_q;

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    out_d    = out_q + CW'(accept) - CW'(rsp);
    drop_d   = drop_q - CW'(rsp_drop);
    cnt_d    = cnt_q + CW'(rsp_keep) - CW'(pop);
    if (accept) begin
      req_pc_d = req_pc_q + 32'd4;
    end
    // Everything still in flight after this edge belongs to the old path
    if (redirect) begin
      req_pc_d = {redirect_target[31:2], 2'b00};
      drop_d   = out_d;
      cnt_d    = '0;
    end
    case (state_q)
      IDLE:       state_d = RUN;
      RUN, DRAIN: state_d = (drop_d != '0) ? DRAIN : RUN;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      req_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      pf_wr_q  <= '0;
      pf_rd_q  <= '0;
      if_wr_q  <= '0;
      if_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      if (redirect) begin
        pf_wr_q <= '0;
        pf_rd_q <= '0;
        if_wr_q <= '0;
        if_rd_q <= '0;
      end else begin
        if (accept) begin
          pf_wr_q <= ptr_inc(pf_wr_q);
        end
        if (rsp_keep) begin
          pf_rd_q <= ptr_inc(pf_rd_q);
          if_wr_q <= ptr_inc(if_wr_q);
        end
        if (pop) begin
          if_rd_q <= ptr_inc(if_rd_q);
        end
      end
    end
  end

  // Storage needs no reset: counts and pointers define what is valid
  always_ff @(posedge clock) begin
    if (accept) begin
      pf_pc[pf_wr_q] <= req_pc_q;
    end
    if (rsp_keep) begin
      if_pc[if_wr_q]   <= pf_pc[pf_rd_q];
      if_inst[if_wr_q] <= imem.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Memory model returns in-order responses; scoreboard tracks the architectural PC stream.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .imem            (bus),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_valid     (fetch_valid),
    .fetch_inst      (fetch_inst),
    .fetch_pc        (fetch_pc)
  );

  pend_t       pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_pc;
  int cyc, last_due, lat, pops, checks, failures;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
    exp_req_pc = pc;
  endtask

  // Called at posedge+1: drive one cycle, score what the DUT shows, advance to next posedge+1
  task automatic step(input logic rdy, input logic stl, input logic rdr, input logic [31:0] tgt);
    pend_t p;
    logic [31:0] e;
    int due;
    bus.imem_req_ready = rdy;
    stall = stl;
    redirect = rdr;
    redirect_target = tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = inst_of(p.addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = 32'h0;
    end
    if (fetch_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream_unexpected got pc=%h expected no valid instruction", fetch_pc);
      end else if (fetch_pc !== exp_q[0] || fetch_inst !== inst_of(exp_q[0])) begin
        failures++;
        $display("FAIL stream got pc=%h inst=%h expected pc=%h inst=%h",
                 fetch_pc, fetch_inst, exp_q[0], inst_of(exp_q[0]));
      end
      if (!stl && !rdr && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_q.push_back(e + 32'd4);
        pops++;
      end
    end else begin
      checks++;
      if (fetch_inst !== NOP) begin
        failures++;
        $display("FAIL bubble_nop got inst=%h expected %h", fetch_inst, NOP);
      end
    end
    if (bus.imem_req_valid && rdy) begin
      checks++;
      if (bus.imem_req_addr !== exp_req_pc) begin
        failures++;
        $display("FAIL req_addr got %h expected %h", bus.imem_req_addr, exp_req_pc);
      end
      exp_req_pc = exp_req_pc + 32'd4;
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      p.addr = bus.imem_req_addr;
      p.due = due;
      pend.push_back(p);
    end
    checks++;
    if (pend.size() > DEPTH) begin
      failures++;
      $display("FAIL credit in_flight got %0d limit %0d", pend.size(), DEPTH);
    end
    if (rdr) sb_restart({tgt[31:2], 2'b00});
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data = 32'h0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got %b expected 0", bus.imem_req_valid); end
    checks++;
    if (bus.imem_req_addr !== RESET_PC) begin failures++; $display("FAIL reset_req_addr got %h expected %h", bus.imem_req_addr, RESET_PC); end
    checks++;
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid got %b expected 0", fetch_valid); end
    checks++;
    if (fetch_inst !== NOP) begin failures++; $display("FAIL reset_fetch_inst got %h expected %h", fetch_inst, NOP); end
    checks++;
    if (fetch_pc !== RESET_PC) begin failures++; $display("FAIL reset_fetch_pc got %h expected %h", fetch_pc, RESET_PC); end
    reset_n = 1'b1;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL idle_req_valid got %b expected 0", bus.imem_req_valid); end
    sb_restart(RESET_PC);
    cyc = 0;
    last_due = 0;
    @(posedge clock);
    #1;
    checks++;
    if (bus.imem_req_valid !== 1'b1) begin failures++; $display("FAIL run_req_valid got %b expected 1", bus.imem_req_valid); end
  endtask

  task automatic test_stream();
    int p0;
    lat = 1;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    p0 = pops;
    repeat (30) step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pops - p0 < 19) begin failures++; $display("FAIL throughput got %0d pops in 30 cycles expected >= 19", pops - p0); end
  endtask

  task automatic test_stall();
    int n, p0;
    lat = 1;
    n = 0;
    while (!fetch_valid && n < 20) begin step(1'b1, 1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (!fetch_valid) begin failures++; $display("FAIL stall_setup timeout got fetch_valid=%b expected 1", fetch_valid); end
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_credit got req_valid=%b expected 0", bus.imem_req_valid); end
        checks++;
        if (fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_hold got fetch_valid=%b expected 1", fetch_valid); end
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    p0 = pops;
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pops - p0 < DEPTH) begin failures++; $display("FAIL stall_resume got %0d pops expected >= %0d", pops - p0, DEPTH); end
  endtask

  task automatic test_redirect_drop();
    int n;
    lat = 3;
    n = 0;
    while (pend.size() != 2 && n < 30) begin step(1'b1, 1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (pend.size() != 2) begin failures++; $display("FAIL drop_setup timeout got in_flight=%0d expected 2", pend.size()); end
    step(1'b1, 1'b0, 1'b1, 32'h0100_0203);
    checks++;
    if (bus.imem_req_addr !== 32'h0100_0200) begin failures++; $display("FAIL redirect_addr got %h expected 01000200", bus.imem_req_addr); end
    checks++;
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL redirect_flush got fetch_valid=%b expected 0", fetch_valid); end
    n = 0;
    while (!fetch_valid && n < 20) begin step(1'b1, 1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (fetch_pc !== 32'h0100_0200 || !fetch_valid) begin
      failures++;
      $display("FAIL redirect_first got valid=%b pc=%h expected valid=1 pc=01000200", fetch_valid, fetch_pc);
    end
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_collide();
    int n;
    lat = 1;
    n = 0;
    while (!(bus.imem_req_valid && pend.size() > 0 && pend[0].due <= cyc) && n < 20) begin
      step(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checks++;
    if (!(bus.imem_req_valid && pend.size() > 0)) begin failures++; $display("FAIL collide_setup timeout got req_valid=%b in_flight=%0d", bus.imem_req_valid, pend.size()); end
    step(1'b1, 1'b0, 1'b1, 32'h0200_0010);
    step(1'b1, 1'b0, 1'b1, 32'h0300_0024);
    n = 0;
    while (!fetch_valid && n < 20) begin step(1'b1, 1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (fetch_pc !== 32'h0300_0024 || !fetch_valid) begin
      failures++;
      $display("FAIL collide_first got valid=%b pc=%h expected valid=1 pc=03000024", fetch_valid, fetch_pc);
    end
    repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    int p0;
    logic seen_zero;
    lat = 1;
    seen_zero = 1'b0;
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9);
    p0 = pops;
    for (int i = 0; i < 15; i++) begin
      if (fetch_valid && fetch_pc === 32'h0) seen_zero = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'h0);
    end
    checks++;
    if (!seen_zero) begin failures++; $display("FAIL wrap got no pc=00000000 expected wrap from fffffffc"); end
    checks++;
    if (pops - p0 < 6) begin failures++; $display("FAIL wrap_progress got %0d pops expected >= 6", pops - p0); end
  endtask

  task automatic test_reset_mid();
    int n, p0;
    lat = 3;
    n = 0;
    while (pend.size() == 0 && n < 20) begin step(1'b1, 1'b0, 1'b0, 32'h0); n++; end
    checks++;
    if (pend.size() == 0) begin failures++; $display("FAIL midreset_setup timeout got in_flight=0 expected >0"); end
    reset_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_inst !== NOP || fetch_pc !== RESET_PC) begin
      failures++;
      $display("FAIL midreset_out got valid=%b inst=%h pc=%h expected 0 %h %h", fetch_valid, fetch_inst, fetch_pc, NOP, RESET_PC);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL midreset_req got valid=%b addr=%h expected 0 %h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    if (pend.size() > 0) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = inst_of(pend[0].addr);
    end
    @(posedge clock);
    #1;
    bus.imem_rsp_valid = 1'b0;
    pend.delete();
    checks++;
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL late_rsp got fetch_valid=%b expected 0", fetch_valid); end
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL refetch got valid=%b addr=%h expected 1 %h", bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
    sb_restart(RESET_PC);
    last_due = cyc;
    lat = 1;
    p0 = pops;
    repeat (15) step(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pops - p0 < 5) begin failures++; $display("FAIL refetch_progress got %0d pops expected >= 5", pops - p0); end
  endtask

  task automatic test_random();
    int p0;
    logic rdy, stl, rdr;
    logic [31:0] tgt;
    p0 = pops;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      rdy = ($urandom_range(0, 9) < 3);
      stl = ($urandom_range(0, 9) < 3);
      rdr = ($urandom_range(0, 19) == 0);
      tgt = 32'h0100_0000 + ($urandom_range(0, 255) * 4) + $urandom_range(0, 3);
      step(rdy, stl, rdr, tgt);
    end
    checks++;
    if (pops - p0 < 20) begin failures++; $display("FAIL random_progress got %0d pops expected >= 20", pops - p0); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    pops = 0;
    lat = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
